// File: rtl/mips_pkg.sv
// Shared MIPS pipeline constants and types: register-index width, the hard-wired zero
// register, and the word / register-index typedefs.
package mips_pkg;
  localparam int XLEN      = 32;
  localparam int NREG      = 32;
  localparam int REG_IDX_W = $clog2(NREG);

  typedef logic [REG_IDX_W-1:0] reg_idx_t;
  typedef logic [XLEN-1:0]      word_t;

  localparam reg_idx_t REG_ZERO = '0;
endpackage

// File: rtl/mips_wb_scoreboard.sv
// Pending-write scoreboard: one saturating counter per architectural register. The counter
// counts up on ID issue and down on WB retire. It also drives the busy lookups for both read
// ports and a sticky over/underflow flag.
module mips_wb_scoreboard
  import mips_pkg::*;
#(
  parameter int CNT_W = 2
) (
  input  logic     clk,
  input  logic     rst,
  input  logic     issue_valid,
  input  reg_idx_t issue_rd,
  input  logic     retire_valid,
  input  reg_idx_t retire_rd,
  input  reg_idx_t rs_addr,
  input  reg_idx_t rt_addr,
  output logic     rs_busy,
  output logic     rt_busy,
  output logic     sb_err
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic [CNT_W-1:0] cnt     [NREG];
  logic [CNT_W-1:0] cnt_nxt [NREG];
  logic             err_set;
  logic             inc;
  logic             dec;

  always_comb begin
    err_set = 1'b0;
    inc     = 1'b0;
    dec     = 1'b0;
    for (int i = 0; i < NREG; i++) begin
      cnt_nxt[i] = cnt[i];
      inc = issue_valid && (issue_rd != REG_ZERO) && (issue_rd == reg_idx_t'(i));
      dec = retire_valid && (retire_rd != REG_ZERO) && (retire_rd == reg_idx_t'(i));
      if (i == 0) begin
        cnt_nxt[i] = '0;
      end else begin
        // A retire with nothing outstanding is an underflow even if an issue lands together.
        if (dec && (cnt[i] == '0)) begin
          err_set = 1'b1;
        end
        if (inc && !dec) begin
          if (cnt[i] == CNT_MAX) err_set = 1'b1;
          else                   cnt_nxt[i] = cnt[i] + CNT_W'(1);
        end else if (dec && !inc && (cnt[i] != '0)) begin
          cnt_nxt[i] = cnt[i] - CNT_W'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NREG; i++) cnt[i] <= '0;
      sb_err <= 1'b0;
    end else begin
      for (int i = 0; i < NREG; i++) cnt[i] <= cnt_nxt[i];
      if (err_set) sb_err <= 1'b1;
    end
  end

  assign rs_busy = (rs_addr != REG_ZERO) && (cnt[rs_addr] != '0);
  assign rt_busy = (rt_addr != REG_ZERO) && (cnt[rt_addr] != '0);

endmodule

// File: rtl/mips_wb_regfile.sv
// MIPS write-back stage and 32x32 register file: WB data select, two combinational read
// ports and the pending-write scoreboard. Define WB_BYPASS_EN for same-cycle write-through.
module mips_wb_regfile
  import mips_pkg::*;
#(
  parameter int CNT_W = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 Reg_Write_WB,
  input  logic                 memToReg_WB,
  input  logic                 writePC_WB,
  input  logic [REG_IDX_W-1:0] Write_Reg_WB,
  input  logic [XLEN-1:0]      ALUout_WB,
  input  logic [XLEN-1:0]      readDataMem_WB,
  input  logic [XLEN-1:0]      PC_WB,
  input  logic [REG_IDX_W-1:0] rs_addr,
  input  logic [REG_IDX_W-1:0] rt_addr,
  output logic [XLEN-1:0]      rs_data,
  output logic [XLEN-1:0]      rt_data,
  input  logic                 issue_valid,
  input  logic [REG_IDX_W-1:0] issue_rd,
  output logic                 rs_busy,
  output logic                 rt_busy,
  output logic [XLEN-1:0]      wb_data,
  output logic                 sb_err
);

  word_t rf [NREG];
  logic  wr_en;

  // The link value has priority over load data.
  assign wb_data = writePC_WB  ? PC_WB :
                   memToReg_WB ? readDataMem_WB : ALUout_WB;
  assign wr_en   = Reg_Write_WB && (Write_Reg_WB != REG_ZERO);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NREG; i++) rf[i] <= '0;
    end else if (wr_en) begin
      rf[Write_Reg_WB] <= wb_data;
    end
  end

`ifdef WB_BYPASS_EN
  assign rs_data = (rs_addr == REG_ZERO)                ? '0      :
                   (wr_en && (rs_addr == Write_Reg_WB)) ? wb_data : rf[rs_addr];
  assign rt_data = (rt_addr == REG_ZERO)                ? '0      :
                   (wr_en && (rt_addr == Write_Reg_WB)) ? wb_data : rf[rt_addr];
`else
  assign rs_data = (rs_addr == REG_ZERO) ? '0 : rf[rs_addr];
  assign rt_data = (rt_addr == REG_ZERO) ? '0 : rf[rt_addr];
`endif

  mips_wb_scoreboard #(
    .CNT_W (CNT_W)
  ) u_sb (
    .clk          (clk),
    .rst          (rst),
    .issue_valid  (issue_valid),
    .issue_rd     (issue_rd),
    .retire_valid (Reg_Write_WB),
    .retire_rd    (Write_Reg_WB),
    .rs_addr      (rs_addr),
    .rt_addr      (rt_addr),
    .rs_busy      (rs_busy),
    .rt_busy      (rt_busy),
    .sb_err       (sb_err)
  );

endmodule
